neuron_mac_accumulator: RTL

//  Upstream stage of the activation tag-check lookup. Streams (input, weight) pairs for one

---
 rtl/neuron_mac_accumulator.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/neuron_mac_accumulator.sv
// neuron_mac_accumulator: streams Q5.11 (input, weight) pairs for one neuron, accumulates
// them at full precision on top of a bias, then rounds and saturates to a 16-bit Q5.11 sum.
`default_nettype none

module neuron_mac_accumulator #(
    parameter int DATAWIDTH   = 16,
    parameter int FRAC_BITS   = 11,
    parameter int ACCWIDTH    = 40,
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_terms,
    input  logic [DATAWIDTH-1:0]   bias,
    input  logic                   activation_sel_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATAWIDTH-1:0]   data_in,
    input  logic [DATAWIDTH-1:0]   weight_in,
    output logic                   sum_valid,
    input  logic                   sum_ready,
    output logic [DATAWIDTH-1:0]   sum,
    output logic                   activation_func,
    output logic                   overflow,
    output logic                   busy
);

    localparam int PRODWIDTH = 2 * DATAWIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACCUM = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic signed [ACCWIDTH-1:0] ROUND_HALF  = ACCWIDTH'(2 ** (FRAC_BITS - 1));
    localparam logic signed [ACCWIDTH-1:0] SUM_MAX_EXT = ACCWIDTH'(2 ** (DATAWIDTH - 1) - 1);
    localparam logic signed [ACCWIDTH-1:0] SUM_MIN_EXT = -SUM_MAX_EXT - ACCWIDTH'(1);
    localparam logic [DATAWIDTH-1:0]       SUM_MAX     = {1'b0, {(DATAWIDTH-1){1'b1}}};
    localparam logic [DATAWIDTH-1:0]       SUM_MIN     = {1'b1, {(DATAWIDTH-1){1'b0}}};

    logic [2:0]                  state;
    logic [2:0]                  next_state;

    logic signed [ACCWIDTH-1:0]  acc;
    logic [COUNT_WIDTH-1:0]      count;
    logic [COUNT_WIDTH-1:0]      num_terms_q;
    logic signed [PRODWIDTH-1:0] prod;
    logic                        prod_valid;
    logic                        act_sel_q;
    logic [DATAWIDTH-1:0]        sum_q;
    logic                        overflow_q;
    logic                        sum_valid_q;

    logic                        handshake;
    logic                        last_pair;
    logic signed [PRODWIDTH-1:0] data_ext;
    logic signed [PRODWIDTH-1:0] weight_ext;
    logic signed [ACCWIDTH-1:0]  prod_ext;
    logic signed [ACCWIDTH-1:0]  bias_ext;
    logic signed [ACCWIDTH-1:0]  rounded;
    logic                        sat_hi;
    logic                        sat_lo;

    assign handshake  = in_valid & in_ready;
    assign last_pair  = handshake && (count == num_terms_q - COUNT_WIDTH'(1));

    assign data_ext   = {{DATAWIDTH{data_in[DATAWIDTH-1]}}, data_in};
    assign weight_ext = {{DATAWIDTH{weight_in[DATAWIDTH-1]}}, weight_in};
    assign prod_ext   = {{(ACCWIDTH-PRODWIDTH){prod[PRODWIDTH-1]}}, prod};
    // Bias is moved onto the Q.22 grid of the products before it seeds the accumulator.
    assign bias_ext   = {{(ACCWIDTH-DATAWIDTH-FRAC_BITS){bias[DATAWIDTH-1]}}, bias,
                         {FRAC_BITS{1'b0}}};

    // Round half up: add half an LSB of the result, then floor via arithmetic shift.
    assign rounded    = (acc + ROUND_HALF) >>> FRAC_BITS;
    assign sat_hi     = rounded > SUM_MAX_EXT;
    assign sat_lo     = rounded < SUM_MIN_EXT;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (num_terms == '0) ? S_DRAIN : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (last_pair) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: next_state = S_ROUND;
            S_ROUND: next_state = S_HOLD;
            S_HOLD: begin
                if (sum_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state)
            S_IDLE:  busy     = 1'b0;
            S_ACCUM: in_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc         <= '0;
            count       <= '0;
            num_terms_q <= '0;
            prod        <= '0;
            prod_valid  <= 1'b0;
            act_sel_q   <= 1'b0;
            sum_q       <= '0;
            overflow_q  <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                num_terms_q <= num_terms;
                act_sel_q   <= activation_sel_in;
                acc         <= bias_ext;
                count       <= '0;
                prod_valid  <= 1'b0;
            end else begin
                // The product register splits the multiply from the add; DRAIN flushes it.
                if (prod_valid) begin
                    acc <= acc + prod_ext;
                end
                if (handshake) begin
                    prod       <= data_ext * weight_ext;
                    prod_valid <= 1'b1;
                    count      <= count + COUNT_WIDTH'(1);
                end else begin
                    prod_valid <= 1'b0;
                end
            end

            if (state == S_ROUND) begin
                sum_valid_q <= 1'b1;
                overflow_q  <= sat_hi | sat_lo;
                if (sat_hi) begin
                    sum_q <= SUM_MAX;
                end else if (sat_lo) begin
                    sum_q <= SUM_MIN;
                end else begin
                    sum_q <= rounded[DATAWIDTH-1:0];
                end
            end else if (state == S_HOLD && sum_ready) begin
                sum_valid_q <= 1'b0;
            end
        end
    end

    assign sum             = sum_q;
    assign overflow        = overflow_q;
    assign sum_valid       = sum_valid_q;
    assign activation_func = act_sel_q;

endmodule

`default_nettype wire
